change_capture: RTL and testbench

Hardware counterpart of the bench monitor: sits on the 16-bit registered output of the datapath and logs every value change with a cycle timestamp. Entries go into a small FIFO, which a downstream reader (debug port or self-checking logic) drains over a valid/ready handshake. It replaces software `$monitor` observation with a synthesizable, cycle-accurate change log.

---
 rtl/change_capture_pkg.sv | 13 +
 rtl/sync_fifo.sv | 59 +++++
 rtl/change_capture.sv | 74 +++++++
 tb/tb_change_capture.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/change_capture_pkg.sv
// Shared constants and entry layout for the change-capture logger.
package change_capture_pkg;

  localparam int CC_DATA_W = 16;
  localparam int CC_TS_W   = 16;
  localparam int CC_DEPTH  = 8;

  typedef struct packed {
    logic [CC_TS_W-1:0]   ts;
    logic [CC_DATA_W-1:0] data;
  } cc_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// FWFT synchronous FIFO: a pushed word is on o_rd_dat the cycle after the push edge.
// Backpressure: pushes are ignored when full unless a pop happens on the same edge.
module sync_fifo #(
  parameter  int W     = 32,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_wr_dat,
  input  logic          i_pop,
  output logic [W-1:0]  o_rd_dat,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_cnt;
  logic [W-1:0]  r_last;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == L_FULL);
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);

  // While empty the last popped word is shown, so the outputs never go X.
  assign o_rd_dat = o_empty ? r_last : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_last   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_last   <= r_mem[r_rd_ptr];
      end
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_dat;
  end

endmodule

// File: rtl/change_capture.sv
// Logs every change of data_in with a timestamp; entry visible one cycle after its sampling edge.
// Reader drains with out_valid/out_ready; captures arriving at a full FIFO are dropped and flagged.
module change_capture
  import change_capture_pkg::*;
#(
  parameter int DATA_W = CC_DATA_W,
  parameter int TS_W   = CC_TS_W,
  parameter int DEPTH  = CC_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     clr_ovf,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [TS_W-1:0]          out_ts,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  logic [TS_W-1:0]        r_ts;
  logic [DATA_W-1:0]      r_prev;
  logic                   r_armed;
  logic                   r_ovf;
  logic                   w_cap;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_drop;
  logic [TS_W+DATA_W-1:0] w_rd_dat;

  // The first enabled sample after reset is always logged, even if it equals r_prev.
  assign w_cap     = en & (~r_armed | (data_in != r_prev));
  assign w_pop     = out_ready & ~w_empty;
  assign w_drop    = w_cap & w_full & ~w_pop;
  assign out_valid = ~w_empty;
  assign overflow  = r_ovf;
  assign {out_ts, out_data} = w_rd_dat;

  sync_fifo #(
    .W     (TS_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .i_push   (w_cap),
    .i_wr_dat ({r_ts, data_in}),
    .i_pop    (w_pop),
    .o_rd_dat (w_rd_dat),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_count  (count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ts    <= '0;
      r_prev  <= '0;
      r_armed <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (en) begin
        r_ts    <= r_ts + 1'b1;
        r_prev  <= data_in;
        r_armed <= 1'b1;
      end
      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_change_capture.sv
// Directed bench for change_capture; narrow timestamp so wrap-around is reachable quickly.
module tb_change_capture;

  localparam int DATA_W = 16;
  localparam int TS_W   = 4;
  localparam int DEPTH  = 8;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   en = 1'b0;
  logic [DATA_W-1:0]      data_in = '0;
  logic                   clr_ovf = 1'b0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [DATA_W-1:0]      out_data;
  logic [TS_W-1:0]        out_ts;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;

  int n_cmp = 0;
  int n_err = 0;

  change_capture #(.DATA_W(DATA_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .data_in   (data_in),
    .clr_ovf   (clr_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ts    (out_ts),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0; data_in = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_vld", 32'(out_valid), 0);
    chk("rst_cnt", 32'(count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_dat", 32'(out_data), 0);
    chk("rst_ts",  32'(out_ts), 0);

    // Constant zero for 10 cycles: exactly one entry (0,0)
    rst = 1'b1; en = 1'b1; data_in = 16'd0;
    repeat (10) @(negedge clk);
    chk("const_cnt", 32'(count), 1);
    chk("const_vld", 32'(out_valid), 1);
    chk("const_ts",  32'(out_ts), 0);
    chk("const_dat", 32'(out_data), 0);
    en = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("const_pop_cnt", 32'(count), 0);
    chk("const_pop_vld", 32'(out_valid), 0);

    // 0 -> 1 at cycle 5, -> 12 at cycle 8, reader always ready
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      data_in = (k < 5) ? 16'd0 : (k < 8) ? 16'd1 : 16'd12;
      @(negedge clk);
      chk("seq_vld", 32'(out_valid), 32'((k == 0) || (k == 5) || (k == 8)));
      if (k == 0 || k == 5 || k == 8) begin
        chk("seq_ts",  32'(out_ts), 32'(k));
        chk("seq_dat", 32'(out_data), (k == 0) ? 0 : (k == 5) ? 1 : 12);
      end
    end

    // Overflow: 9 distinct values, no reader; then a drop with clr_ovf (set wins)
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 9; k++) begin
      data_in = 16'(100 + k);
      @(negedge clk);
    end
    chk("ovf_cnt", 32'(count), 8);
    chk("ovf_flag", 32'(overflow), 1);
    data_in = 16'd200; clr_ovf = 1'b1;
    @(negedge clk);
    chk("ovf_setwins", 32'(overflow), 1);
    chk("ovf_cnt2", 32'(count), 8);
    clr_ovf = 1'b0; en = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_vld", 32'(out_valid), 1);
      chk("drain_ts",  32'(out_ts), 32'(i));
      chk("drain_dat", 32'(out_data), 32'(100 + i));
      @(negedge clk);
    end
    chk("drain_empty", 32'(out_valid), 0);
    chk("drain_cnt", 32'(count), 0);
    chk("drain_ovf_held", 32'(overflow), 1);
    out_ready = 1'b0; clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("ovf_clr", 32'(overflow), 0);

    // Full FIFO with push and pop on the same edge
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      data_in = 16'(10 + k);
      @(negedge clk);
    end
    chk("fp_full_cnt", 32'(count), 8);
    data_in = 16'd50; out_ready = 1'b1;
    @(negedge clk);
    chk("fp_cnt", 32'(count), 8);
    chk("fp_ovf", 32'(overflow), 0);
    en = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk("fp_ts",  32'(out_ts), 32'(i));
      chk("fp_dat", 32'(out_data), (i == 8) ? 50 : 32'(10 + i));
      @(negedge clk);
    end
    chk("fp_end_cnt", 32'(count), 0);

    // Enable gap: changes while disabled are not logged, ts resumes
    do_reset();
    en = 1'b1; out_ready = 1'b1; data_in = 16'd3;
    repeat (3) @(negedge clk);
    chk("gap_pre_vld", 32'(out_valid), 0);
    en = 1'b0;
    for (int v = 4; v <= 7; v++) begin
      data_in = 16'(v);
      @(negedge clk);
      chk("gap_vld", 32'(out_valid), 0);
    end
    en = 1'b1;
    @(negedge clk);
    chk("gap_re_vld", 32'(out_valid), 1);
    chk("gap_re_ts",  32'(out_ts), 3);
    chk("gap_re_dat", 32'(out_data), 7);
    @(negedge clk);
    chk("gap_once", 32'(out_valid), 0);

    // Asynchronous reset with entries queued
    do_reset();
    en = 1'b1;
    for (int v = 1; v <= 3; v++) begin
      data_in = 16'(v);
      @(negedge clk);
    end
    chk("ar_cnt", 32'(count), 3);
    en = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("ar_vld", 32'(out_valid), 0);
    chk("ar_cnt0", 32'(count), 0);
    chk("ar_dat", 32'(out_data), 0);
    chk("ar_ts",  32'(out_ts), 0);
    @(negedge clk);
    rst = 1'b1; en = 1'b1; data_in = 16'd9;
    @(negedge clk);
    chk("ar_post_vld", 32'(out_valid), 1);
    chk("ar_post_ts",  32'(out_ts), 0);
    chk("ar_post_dat", 32'(out_data), 9);
    chk("ar_post_cnt", 32'(count), 1);

    // Timestamp wrap: 16 enabled cycles bring a 4-bit ts back to 0
    do_reset();
    en = 1'b1; out_ready = 1'b1; data_in = 16'd5;
    repeat (16) @(negedge clk);
    data_in = 16'd6;
    @(negedge clk);
    chk("wrap_ts0",  32'(out_ts), 0);
    chk("wrap_dat0", 32'(out_data), 6);
    data_in = 16'd7;
    @(negedge clk);
    chk("wrap_ts1",  32'(out_ts), 1);
    chk("wrap_dat1", 32'(out_data), 7);
    chk("wrap_cnt",  32'(count), 1);
    en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
